// File: rtl/out_backprop.sv
// rtl/out_backprop.sv - output-layer backprop engine: sigmoid deltas, SGD weight/bias update, hidden error
module out_backprop #(
  parameter int NUM_INPUT = 3,
  parameter int NUM_PCTN  = 2,
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [NUM_PCTN*WIDTH-1:0]           i_a,
  input  logic [NUM_PCTN*WIDTH-1:0]           i_t,
  input  logic [NUM_INPUT*WIDTH-1:0]          i_k,
  input  logic [NUM_PCTN*NUM_INPUT*WIDTH-1:0] i_w,
  input  logic [NUM_PCTN*WIDTH-1:0]           i_b,
  input  logic [WIDTH-1:0]                    i_lr,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [NUM_PCTN*NUM_INPUT*WIDTH-1:0] o_w,
  output logic [NUM_PCTN*WIDTH-1:0]           o_b,
  output logic [NUM_INPUT*WIDTH-1:0]          o_e
);

  localparam int JW = (NUM_PCTN > 1) ? $clog2(NUM_PCTN) : 1;
  localparam int IW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_DLT0, S_DLT1, S_GRD, S_UPD, S_DONE} state_t;

  state_t                  state;
  logic [JW-1:0]           j_idx;
  logic [IW-1:0]           i_idx;
  logic signed [WIDTH-1:0] a_l   [NUM_PCTN];
  logic signed [WIDTH-1:0] t_l   [NUM_PCTN];
  logic signed [WIDTH-1:0] b_l   [NUM_PCTN];
  logic signed [WIDTH-1:0] k_l   [NUM_INPUT];
  logic signed [WIDTH-1:0] acc   [NUM_INPUT];
  logic signed [WIDTH-1:0] w_l   [NUM_PCTN][NUM_INPUT];
  logic signed [WIDTH-1:0] lr_l;
  logic signed [WIDTH-1:0] p_r;
  logic signed [WIDTH-1:0] delta_r;
  logic signed [WIDTH-1:0] g_r;

  logic signed [WIDTH-1:0] g_next;
  logic signed [WIDTH-1:0] w_cur;
  logic signed [WIDTH-1:0] w_upd;
  logic signed [WIDTH-1:0] acc_upd;

  // Fixed-point multiply: full-width product, floor shift by FRAC, wrap to WIDTH
  function automatic logic signed [WIDTH-1:0] fmul(input logic signed [WIDTH-1:0] x,
                                                   input logic signed [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] prod;
    prod = {{WIDTH{x[WIDTH-1]}}, x} * {{WIDTH{y[WIDTH-1]}}, y};
    prod = prod >>> FRAC;
    return prod[WIDTH-1:0];
  endfunction

  // Gradient step and the per-cycle weight/error update for element (j_idx, i_idx)
  always_comb begin
    g_next  = fmul(lr_l, delta_r);
    w_cur   = w_l[j_idx][i_idx];
    w_upd   = w_cur - fmul(g_r, k_l[i_idx]);
    acc_upd = acc[i_idx] + fmul(w_cur, delta_r);
  end

  // Sequencer: latch on accept, walk DLT0/DLT1/GRD/UPD per perceptron, publish at DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      j_idx   <= '0;
      i_idx   <= '0;
      lr_l    <= '0;
      p_r     <= '0;
      delta_r <= '0;
      g_r     <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_w     <= '0;
      o_b     <= '0;
      o_e     <= '0;
      for (int jj = 0; jj < NUM_PCTN; jj++) begin
        a_l[jj] <= '0;
        t_l[jj] <= '0;
        b_l[jj] <= '0;
        for (int ii = 0; ii < NUM_INPUT; ii++) w_l[jj][ii] <= '0;
      end
      for (int ii = 0; ii < NUM_INPUT; ii++) begin
        k_l[ii] <= '0;
        acc[ii] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            for (int jj = 0; jj < NUM_PCTN; jj++) begin
              a_l[jj] <= i_a[jj*WIDTH +: WIDTH];
              t_l[jj] <= i_t[jj*WIDTH +: WIDTH];
              b_l[jj] <= i_b[jj*WIDTH +: WIDTH];
              for (int ii = 0; ii < NUM_INPUT; ii++)
                w_l[jj][ii] <= i_w[(jj*NUM_INPUT+ii)*WIDTH +: WIDTH];
            end
            for (int ii = 0; ii < NUM_INPUT; ii++) begin
              k_l[ii] <= i_k[ii*WIDTH +: WIDTH];
              acc[ii] <= '0;
            end
            lr_l   <= i_lr;
            j_idx  <= '0;
            i_idx  <= '0;
            o_busy <= 1'b1;
            state  <= S_DLT0;
          end
        end
        S_DLT0: begin
          p_r   <= fmul(a_l[j_idx] - t_l[j_idx], a_l[j_idx]);
          state <= S_DLT1;
        end
        S_DLT1: begin
          delta_r <= fmul(p_r, ONE - a_l[j_idx]);
          state   <= S_GRD;
        end
        S_GRD: begin
          g_r        <= g_next;
          b_l[j_idx] <= b_l[j_idx] - g_next;
          i_idx      <= '0;
          state      <= S_UPD;
        end
        S_UPD: begin
          w_l[j_idx][i_idx] <= w_upd;
          acc[i_idx]        <= acc_upd;
          if (i_idx == IW'(NUM_INPUT-1)) begin
            if (j_idx == JW'(NUM_PCTN-1)) begin
              // The element being updated this cycle is taken from the comb path
              for (int jj = 0; jj < NUM_PCTN; jj++) begin
                o_b[jj*WIDTH +: WIDTH] <= b_l[jj];
                for (int ii = 0; ii < NUM_INPUT; ii++)
                  o_w[(jj*NUM_INPUT+ii)*WIDTH +: WIDTH] <=
                    (JW'(jj) == j_idx && IW'(ii) == i_idx) ? w_upd : w_l[jj][ii];
              end
              for (int ii = 0; ii < NUM_INPUT; ii++)
                o_e[ii*WIDTH +: WIDTH] <= (IW'(ii) == i_idx) ? acc_upd : acc[ii];
              o_done <= 1'b1;
              state  <= S_DONE;
            end else begin
              j_idx <= j_idx + JW'(1);
              state <= S_DLT0;
            end
          end else begin
            i_idx <= i_idx + IW'(1);
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_backprop.sv
// tb/tb_out_backprop.sv - scoreboard bench for out_backprop against a behavioural model
module tb_out_backprop;
  localparam int NI = 3;
  localparam int NP = 2;
  localparam int W  = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start;
  logic [NP*W-1:0]    i_a, i_t, i_b;
  logic [NI*W-1:0]    i_k;
  logic [NP*NI*W-1:0] i_w;
  logic [W-1:0]       i_lr;
  logic               o_busy, o_done;
  logic [NP*NI*W-1:0] o_w;
  logic [NP*W-1:0]    o_b;
  logic [NI*W-1:0]    o_e;

  out_backprop #(.NUM_INPUT(NI), .NUM_PCTN(NP), .WIDTH(W), .FRAC(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_a(i_a), .i_t(i_t), .i_k(i_k), .i_w(i_w), .i_b(i_b), .i_lr(i_lr),
    .o_busy(o_busy), .o_done(o_done), .o_w(o_w), .o_b(o_b), .o_e(o_e)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [NP*NI*W-1:0] w;
    logic [NP*W-1:0]    b;
    logic [NI*W-1:0]    e;
    int                 done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int fm(input int x, input int y);
    longint p;
    p = longint'(x) * longint'(y);
    p = p >>> 16;
    return int'(p);
  endfunction

  // Reference: delta_j = (a-t)*a*(1-a); g = lr*delta; b' = b-g; w' = w-g*k; e_i = sum_j w_ji*delta_j
  function automatic exp_t model(input logic [NP*W-1:0] a, input logic [NP*W-1:0] t,
                                 input logic [NP*W-1:0] b, input logic [NI*W-1:0] k,
                                 input logic [NP*NI*W-1:0] w, input logic [W-1:0] lr);
    exp_t r;
    int   e [NI];
    int   aj, tj, d, g, wo;
    for (int i = 0; i < NI; i++) e[i] = 0;
    r.w = '0; r.b = '0; r.e = '0; r.done_cyc = 0;
    for (int j = 0; j < NP; j++) begin
      aj = int'(a[j*W +: W]);
      tj = int'(t[j*W +: W]);
      d  = fm(fm(aj - tj, aj), 32'sh10000 - aj);
      g  = fm(int'(lr), d);
      r.b[j*W +: W] = int'(b[j*W +: W]) - g;
      for (int i = 0; i < NI; i++) begin
        wo = int'(w[(j*NI+i)*W +: W]);
        r.w[(j*NI+i)*W +: W] = wo - fm(g, int'(k[i*W +: W]));
        e[i] += fm(wo, d);
      end
    end
    for (int i = 0; i < NI; i++) r.e[i*W +: W] = e[i];
    return r;
  endfunction

  // Monitor: every o_done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t ex;
    if (!rst && o_done) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL spurious_done: got o_done=1 expected no pending run (cycle %0d)", cyc);
      end else begin
        ex = sbq.pop_front();
        chk("done_latency", 256'(cyc), 256'(ex.done_cyc));
        chk("o_w", 256'(o_w), 256'(ex.w));
        chk("o_b", 256'(o_b), 256'(ex.b));
        chk("o_e", 256'(o_e), 256'(ex.e));
      end
    end
  end

  function automatic logic [NP*NI*W-1:0] rnd_w();
    logic [NP*NI*W-1:0] v;
    for (int n = 0; n < NP*NI; n++) v[n*W +: W] = $urandom;
    return v;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((o_busy || o_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_total++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic issue(input logic [NP*W-1:0] a, input logic [NP*W-1:0] t,
                       input logic [NI*W-1:0] k, input logic [NP*NI*W-1:0] w,
                       input logic [NP*W-1:0] b, input logic [W-1:0] lr, input bit perturb);
    exp_t ex;
    wait_idle();
    i_a = a; i_t = t; i_k = k; i_w = w; i_b = b; i_lr = lr;
    i_start = 1'b1;
    ex = model(a, t, b, k, w, lr);
    ex.done_cyc = cyc + 13;
    sbq.push_back(ex);
    @(posedge clk);
    #1 i_start = 1'b0;
    chk("busy_after_accept", 256'(o_busy), 256'(1));
    if (perturb) begin
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        i_a = {$urandom, $urandom};
        i_t = {$urandom, $urandom};
        i_w = rnd_w();
        i_lr = $urandom;
        i_start = 1'($urandom % 2);
      end
      @(negedge clk);
      i_start = 1'b0;
    end
  endtask

  task automatic abort_run();
    wait_idle();
    i_a = {$urandom, $urandom}; i_t = {$urandom, $urandom};
    i_k = {$urandom, $urandom, $urandom}; i_w = rnd_w();
    i_b = {$urandom, $urandom}; i_lr = $urandom;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_o_busy", 256'(o_busy), 256'(0));
    chk("abort_o_done", 256'(o_done), 256'(0));
    chk("abort_o_w", 256'(o_w), 256'(0));
    chk("abort_o_b", 256'(o_b), 256'(0));
    chk("abort_o_e", 256'(o_e), 256'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic back_to_back();
    exp_t ex;
    int   c;
    wait_idle();
    i_a = {32'h0000_9000, 32'h0000_3000}; i_t = {32'h0000_1000, 32'h0000_F000};
    i_k = {32'h0001_0000, 32'hFFFF_8000, 32'h0000_4000};
    i_w = rnd_w(); i_b = {$urandom, $urandom}; i_lr = 32'h0000_8000;
    i_start = 1'b1;
    c = cyc;
    ex = model(i_a, i_t, i_b, i_k, i_w, i_lr);
    for (int r = 0; r < 3; r++) begin
      ex.done_cyc = c + 13 + 14*r;
      sbq.push_back(ex);
    end
    while (cyc < c + 29) @(negedge clk);
    i_start = 1'b0;
  endtask

  logic [NP*NI*W-1:0] w_half;

  initial begin
    rst = 1'b1; i_start = 1'b0;
    i_a = '0; i_t = '0; i_k = '0; i_w = '0; i_b = '0; i_lr = '0;
    #2;
    chk("reset_o_busy", 256'(o_busy), 256'(0));
    chk("reset_o_done", 256'(o_done), 256'(0));
    chk("reset_o_w", 256'(o_w), 256'(0));
    chk("reset_o_b", 256'(o_b), 256'(0));
    chk("reset_o_e", 256'(o_e), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < NP*NI; n++) w_half[n*W +: W] = 32'h0000_8000;

    // zero error: results equal inputs, error zero
    issue({32'h8000, 32'h8000}, {32'h8000, 32'h8000}, {$urandom, $urandom, $urandom},
          w_half, {32'h10000, 32'h10000}, 32'h10000, 1'b0);
    // positive delta on perceptron 0
    issue({32'h8000, 32'hC000}, {32'h8000, 32'h0}, {32'h0, 32'h0, 32'h10000},
          w_half, {32'h10000, 32'h0}, 32'h10000, 1'b0);
    // negative delta with floor rounding
    issue({32'h8000, 32'h4000}, {32'h8000, 32'h10000}, {32'h0, 32'h0, 32'h10000},
          w_half, {32'h10000, 32'h0}, 32'h8000, 1'b0);

    // mid-run reset discards the run, then a fresh run completes normally
    abort_run();
    issue({32'h2000, 32'hE000}, {32'h0, 32'h10000}, {32'h10000, 32'h8000, 32'h4000},
          rnd_w(), {$urandom, $urandom}, 32'h4000, 1'b0);

    back_to_back();

    for (int r = 0; r < 14; r++)
      issue({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom, $urandom},
            rnd_w(), {$urandom, $urandom}, $urandom, 1'(r % 2));

    begin
      int n = 0;
      while (sbq.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("scoreboard_drained", 256'(sbq.size()), 256'(0));
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
